axis_split: RTL and testbench

//  1-to-2 AXI-Stream router, the fan-out counterpart of the 2-to-1 stream merge in the datapath.

---
 rtl/axis_split_pkg.sv | 15 +
 rtl/axis_fifo2.sv | 53 +++++
 rtl/axis_split.sv | 77 +++++++
 tb/tb_axis_split.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_split_pkg.sv
// Shared constants and helpers for the 1-to-2 AXI-Stream splitter.
package axis_split_pkg;

  localparam logic        ROUTE_M00        = 1'b0;
  localparam logic        ROUTE_M01        = 1'b1;
  localparam int unsigned AXIS_SPLIT_DEPTH = 2;

  typedef logic [1:0] fifo_cnt_t;

  // A full FIFO still takes a beat when its head leaves on the same edge.
  function automatic logic fifo_push_ok(input fifo_cnt_t cnt, input logic pop_rdy);
    return (cnt < fifo_cnt_t'(AXIS_SPLIT_DEPTH)) || pop_rdy;
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI-Stream FIFO with 1-bit wrapping pointers; push and pop may coincide at any fill.
module axis_fifo2
  import axis_split_pkg::*;
#(
  parameter int unsigned DATA_WD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_axis_tvalid,
  input  logic [DATA_WD-1:0] s_axis_tdata,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_WD-1:0] m_axis_tdata,
  input  logic               m_axis_tready,
  output fifo_cnt_t          count
);

  logic [DATA_WD-1:0] r_mem [AXIS_SPLIT_DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  fifo_cnt_t          r_count;
  logic               w_push;
  logic               w_pop;

  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = r_mem[r_rd_ptr];
  assign s_axis_tready = fifo_push_ok(r_count, m_axis_tready);
  assign count         = r_count;

  assign w_push = s_axis_tvalid & s_axis_tready;
  assign w_pop  = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < AXIS_SPLIT_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_axis_tdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_split.sv
// 1-to-2 AXI-Stream router: input register, routing on one tdata bit, one 2-entry FIFO per branch.
module axis_split
  import axis_split_pkg::*;
#(
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned SEL_BIT = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_axis_tvalid,
  input  logic [DATA_WD-1:0] s_axis_tdata,
  output logic               s_axis_tready,
  output logic               m00_axis_tvalid,
  output logic [DATA_WD-1:0] m00_axis_tdata,
  input  logic               m00_axis_tready,
  output logic               m01_axis_tvalid,
  output logic [DATA_WD-1:0] m01_axis_tdata,
  input  logic               m01_axis_tready
);

  logic               r_in_valid;
  logic [DATA_WD-1:0] r_in_data;
  logic               w_dest;
  logic               w_push_ok;
  logic               w_fifo0_rdy;
  logic               w_fifo1_rdy;
  logic               w_drain;
  logic               w_accept;
  fifo_cnt_t          w_cnt0;
  fifo_cnt_t          w_cnt1;

  assign w_dest    = r_in_data[SEL_BIT];
  assign w_push_ok = (w_dest == ROUTE_M01) ? fifo_push_ok(w_cnt1, m01_axis_tready)
                                           : fifo_push_ok(w_cnt0, m00_axis_tready);
  assign w_drain   = r_in_valid & ((w_dest == ROUTE_M01) ? w_fifo1_rdy : w_fifo0_rdy);

  // Held low while in reset so no beat is taken across the release edge.
  assign s_axis_tready = rst_n & (~r_in_valid | w_push_ok);
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
    end else if (w_accept) begin
      r_in_valid <= 1'b1;
      r_in_data  <= s_axis_tdata;
    end else if (w_drain) begin
      r_in_valid <= 1'b0;
    end
  end

  axis_fifo2 #(.DATA_WD(DATA_WD)) u_fifo0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (r_in_valid & (w_dest == ROUTE_M00)),
    .s_axis_tdata  (r_in_data),
    .s_axis_tready (w_fifo0_rdy),
    .m_axis_tvalid (m00_axis_tvalid),
    .m_axis_tdata  (m00_axis_tdata),
    .m_axis_tready (m00_axis_tready),
    .count         (w_cnt0)
  );

  axis_fifo2 #(.DATA_WD(DATA_WD)) u_fifo1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (r_in_valid & (w_dest == ROUTE_M01)),
    .s_axis_tdata  (r_in_data),
    .s_axis_tready (w_fifo1_rdy),
    .m_axis_tvalid (m01_axis_tvalid),
    .m_axis_tdata  (m01_axis_tdata),
    .m_axis_tready (m01_axis_tready),
    .count         (w_cnt1)
  );

endmodule

// File: tb/tb_axis_split.sv
// Self-checking bench for axis_split: queue-based reference model plus directed literal checks.
module tb_axis_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tready;
  logic        m00_tvalid, m01_tvalid;
  logic [63:0] m00_tdata, m01_tdata;
  logic        m00_tready = 1'b0;
  logic        m01_tready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_split #(.DATA_WD(64), .SEL_BIT(63)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tdata    (s_tdata),
    .s_axis_tready   (s_tready),
    .m00_axis_tvalid (m00_tvalid),
    .m00_axis_tdata  (m00_tdata),
    .m00_axis_tready (m00_tready),
    .m01_axis_tvalid (m01_tvalid),
    .m01_axis_tdata  (m01_tdata),
    .m01_axis_tready (m01_tready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one holding slot, then a bounded queue per branch.
  logic [63:0] q0[$], q1[$], rx0[$], rx1[$];
  bit          mv = 0;
  logic [63:0] md = '0;

  function automatic bit mod_push_ok(input bit d);
    return d ? (q1.size() < 2 || m01_tready) : (q0.size() < 2 || m00_tready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mv = 0;
      md = '0;
    end else begin
      bit drn, acc;
      drn = mv && mod_push_ok(md[63]);
      acc = s_tvalid && (!mv || drn);
      if (q0.size() != 0 && m00_tready) rx0.push_back(q0.pop_front());
      if (q1.size() != 0 && m01_tready) rx1.push_back(q1.pop_front());
      if (drn) begin
        if (md[63]) q1.push_back(md);
        else        q0.push_back(md);
      end
      if (acc) begin
        mv = 1;
        md = s_tdata;
      end else if (drn) begin
        mv = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_tready", 64'(s_tready), 64'(rst_n && (!mv || mod_push_ok(md[63]))));
    chk("m00_tvalid", 64'(m00_tvalid), 64'(q0.size() != 0));
    if (q0.size() != 0) chk("m00_tdata", m00_tdata, q0[0]);
    chk("m01_tvalid", 64'(m01_tvalid), 64'(q1.size() != 0));
    if (q1.size() != 0) chk("m01_tdata", m01_tdata, q1[0]);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted; returns the number of stalled cycles.
  task automatic send(input logic [63:0] d, output int stalls);
    stalls   = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(negedge clk);
    while (!s_tready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    chk("send_accept", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot, b0, b1;

    // Reset with a beat offered
    rst_n = 1'b0; s_tvalid = 1'b1; s_tdata = 64'h8000_0000_0000_00AA;
    m00_tready = 1'b1; m01_tready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m00_tvalid", 64'(m00_tvalid), 64'd0);
    chk("rst_m01_tvalid", 64'(m01_tvalid), 64'd0);
    @(posedge clk); #1;
    s_tvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);
    chk("post_rst_m00_tvalid", 64'(m00_tvalid), 64'd0);
    tick(1);

    // Routing and minimum latency
    b0 = rx0.size(); b1 = rx1.size();
    s_tvalid = 1'b1; s_tdata = 64'h0000_0000_0000_0011;
    @(posedge clk); #1;
    s_tdata = 64'h8000_0000_0000_0022;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("route_m00_tvalid_e2", 64'(m00_tvalid), 64'd1);
    chk("route_m00_tdata_e2", m00_tdata, 64'h0000_0000_0000_0011);
    chk("route_m01_tvalid_e2", 64'(m01_tvalid), 64'd0);
    @(negedge clk);
    chk("route_m01_tvalid_e3", 64'(m01_tvalid), 64'd1);
    chk("route_m01_tdata_e3", m01_tdata, 64'h8000_0000_0000_0022);
    chk("route_m00_tvalid_e3", 64'(m00_tvalid), 64'd0);
    tick(3);
    chk("route_rx0_cnt", 64'(rx0.size() - b0), 64'd1);
    chk("route_rx1_cnt", 64'(rx1.size() - b1), 64'd1);
    chk("route_rx0_val", rx0[b0], 64'h0000_0000_0000_0011);
    chk("route_rx1_val", rx1[b1], 64'h8000_0000_0000_0022);

    // Sustained throughput on m00
    b0 = rx0.size(); tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(64'h100 + 64'(i), st);
      tot += st;
    end
    chk("tput_stalls", 64'(tot), 64'd0);
    tick(4);
    chk("tput_rx0_cnt", 64'(rx0.size() - b0), 64'd16);
    for (int i = 0; i < 16; i++) chk("tput_order", rx0[b0 + i], 64'h100 + 64'(i));

    // Backpressure on m01
    m01_tready = 1'b0; b1 = rx1.size();
    for (int i = 0; i < 3; i++) send(64'h8000_0000_0000_0A00 + 64'(i), st);
    @(negedge clk);
    chk("bp_s_tready_full", 64'(s_tready), 64'd0);
    chk("bp_m01_tvalid", 64'(m01_tvalid), 64'd1);
    chk("bp_m01_head", m01_tdata, 64'h8000_0000_0000_0A00);
    s_tvalid = 1'b1; s_tdata = 64'h8000_0000_0000_0A03;
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_tready_hold", 64'(s_tready), 64'd0);
      chk("bp_m01_head_hold", m01_tdata, 64'h8000_0000_0000_0A00);
    end
    @(posedge clk); #1;
    m01_tready = 1'b1;
    send(64'h8000_0000_0000_0A03, st);
    tick(6);
    chk("bp_rx1_cnt", 64'(rx1.size() - b1), 64'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", rx1[b1 + i], 64'h8000_0000_0000_0A00 + 64'(i));

    // Head-of-line blocking
    m01_tready = 1'b0; m00_tready = 1'b1; b1 = rx1.size();
    for (int i = 0; i < 3; i++) send(64'h8000_0000_0000_0B00 + 64'(i), st);
    b0 = rx0.size();
    s_tvalid = 1'b1; s_tdata = 64'h0000_0000_0000_0B10;
    repeat (4) begin
      @(negedge clk);
      chk("hol_s_tready", 64'(s_tready), 64'd0);
      chk("hol_m00_tvalid", 64'(m00_tvalid), 64'd0);
    end
    @(posedge clk); #1;
    m01_tready = 1'b1;
    send(64'h0000_0000_0000_0B10, st);
    tick(6);
    chk("hol_rx0_cnt", 64'(rx0.size() - b0), 64'd1);
    chk("hol_rx0_val", rx0[b0], 64'h0000_0000_0000_0B10);
    chk("hol_rx1_cnt", 64'(rx1.size() - b1), 64'd3);

    // Asynchronous reset with both FIFOs full
    m00_tready = 1'b0; m01_tready = 1'b0;
    send(64'h0000_0000_0000_0C00, st);
    send(64'h0000_0000_0000_0C01, st);
    send(64'h8000_0000_0000_0C02, st);
    send(64'h8000_0000_0000_0C03, st);
    tick(2);
    chk("ar_m00_full_valid", 64'(m00_tvalid), 64'd1);
    chk("ar_m01_full_valid", 64'(m01_tvalid), 64'd1);
    chk("ar_s_tready_full", 64'(s_tready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_m00_tvalid_drop", 64'(m00_tvalid), 64'd0);
    chk("ar_m01_tvalid_drop", 64'(m01_tvalid), 64'd0);
    chk("ar_s_tready_drop", 64'(s_tready), 64'd0);
    b0 = rx0.size(); b1 = rx1.size();
    m00_tready = 1'b1; m01_tready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("ar_no_stale_m00", 64'(rx0.size() - b0), 64'd0);
    chk("ar_no_stale_m01", 64'(rx1.size() - b1), 64'd0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
